ddc_capture_buffer: RTL and testbench

Snapshot capture buffer directly downstream of the DDC output stage. Takes the DDC's decimated baseband I/Q stream (18-bit samples qualified by the DDC sync strobe), waits for an armed trigger, stores a programmable-length record into on-chip RAM, and lets the microprocessor read the record back through the standard register bus. Provides software with constellation and spectrum snapshots without stalling the demodulator path; the DDC output is observed only, never back-pressured.

---
 rtl/ddc_capture_buffer.sv | 187 ++++++++++++++++++
 tb/tb_ddc_capture_buffer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddc_capture_buffer.sv
// Snapshot capture buffer for the DDC baseband I/Q stream.
// It arms on a software command and triggers either on the next sample or
// on a magnitude threshold. It stores a decimated record of LENGTH+1 samples
// into on-chip RAM, and software reads the record back over the micro bus.
// The DDC stream is only observed; it is never stalled.
module ddc_capture_buffer #(
  parameter int DEPTH_LOG2 = 10,
  parameter int DATA_W     = 18
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr0,
  input  logic                     wr1,
  input  logic                     wr2,
  input  logic                     wr3,
  input  logic [12:0]              addr,
  input  logic [31:0]              din,
  input  logic                     regCs,
  input  logic                     bufCs,
  output logic [31:0]              dout,
  input  logic                     syncIn,
  input  logic signed [DATA_W-1:0] iIn,
  input  logic signed [DATA_W-1:0] qIn,
  output logic                     captureDone
);

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, CAPTURE = 2'd2, DONE = 2'd3} state_t;

  // Magnitude of a two's-complement sample. The most negative code saturates
  // to the largest positive value so that it still fits the unsigned width.
  function automatic logic [DATA_W-1:0] absSat(input logic signed [DATA_W-1:0] x);
    logic [DATA_W-1:0] neg;
    neg = ~x + 1'b1;
    if (!x[DATA_W-1])          return x;
    else if (neg[DATA_W-1])    return {1'b0, {(DATA_W-1){1'b1}}};
    else                       return neg;
  endfunction

  state_t                   state;
  logic                     modeReg, modeLat, modeNxt;
  logic [3:0]               decimReg, decimLat, decimNxt;
  logic [9:0]               lengthReg, lengthNxt;
  logic [DEPTH_LOG2-1:0]    lengthLat;
  logic [DATA_W-1:0]        threshReg, threshNxt;
  logic [DEPTH_LOG2-1:0]    wrPtr, count;
  logic [3:0]               decCnt;
  logic                     vld_p0;
  logic signed [DATA_W-1:0] iSample_p0, qSample_p0;
  logic                     ctrlSel, threshSel, armReq, abortReq, armNow;
  logic                     hit, take, lastWrite;
  logic [31:0]              word, regMux, regQ, ramQ;
  logic                     bufSel;
  logic [9:0]               countExt;
  logic                     unusedBits;
  logic [31:0]              mem [0:(1<<DEPTH_LOG2)-1];

  assign unusedBits = ^{addr, din};

  // Register decode, byte-lane merge and trigger qualification.
  always_comb begin
    ctrlSel   = regCs && (addr[3:2] == 2'd0);
    threshSel = regCs && (addr[3:2] == 2'd1);
    armReq    = ctrlSel && wr0 && din[0];
    abortReq  = ctrlSel && wr0 && din[1];
    // ARM is honoured only from IDLE or DONE, and ABORT overrides it.
    armNow    = armReq && !abortReq && (state == IDLE || state == DONE);

    modeNxt   = modeReg;
    decimNxt  = decimReg;
    lengthNxt = lengthReg;
    if (ctrlSel && wr0) begin
      modeNxt  = din[2];
      decimNxt = din[7:4];
    end
    if (ctrlSel && wr2) lengthNxt[7:0] = din[23:16];
    if (ctrlSel && wr3) lengthNxt[9:8] = din[25:24];

    threshNxt = threshReg;
    if (threshSel && wr0) threshNxt[7:0]         = din[7:0];
    if (threshSel && wr1) threshNxt[15:8]        = din[15:8];
    if (threshSel && wr2) threshNxt[DATA_W-1:16] = din[DATA_W-1:16];

    hit = !modeLat || (absSat(iSample_p0) >= threshReg) || (absSat(qSample_p0) >= threshReg);
    take = vld_p0 && !abortReq &&
           ((state == ARMED && hit) || (state == CAPTURE && decCnt == decimLat));
    lastWrite = (wrPtr == lengthLat);
    word = {iSample_p0[DATA_W-1 -: 16], qSample_p0[DATA_W-1 -: 16]};

    countExt = '0;
    countExt[DEPTH_LOG2-1:0] = count;
    case (addr[3:2])
      2'd0:    regMux = {6'd0, lengthReg, 8'd0, decimReg, 1'b0, modeReg, 2'd0};
      2'd1:    regMux = {{(32-DATA_W){1'b0}}, threshReg};
      2'd2:    regMux = {6'd0, countExt, 14'd0, state};
      default: regMux = '0;
    endcase
  end

  // Stage p0: register the incoming sample. A sample that arrives in the
  // same cycle as the ARM write predates the arm and is discarded.
  always_ff @(posedge clk) begin
    iSample_p0 <= iIn;
    qSample_p0 <= qIn;
  end

  // Qualifier for the p0 sample.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) vld_p0 <= 1'b0;
    else        vld_p0 <= syncIn && !armNow;
  end

  // Software-visible CONTROL and THRESH fields.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      modeReg   <= 1'b0;
      decimReg  <= '0;
      lengthReg <= '0;
      threshReg <= '0;
    end else begin
      modeReg   <= modeNxt;
      decimReg  <= decimNxt;
      lengthReg <= lengthNxt;
      threshReg <= threshNxt;
    end
  end

  // Capture state machine. The record parameters are latched on ARM, so
  // rewriting CONTROL mid-record does not disturb the record in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      wrPtr       <= '0;
      decCnt      <= '0;
      count       <= '0;
      modeLat     <= 1'b0;
      decimLat    <= '0;
      lengthLat   <= '0;
      captureDone <= 1'b0;
    end else begin
      captureDone <= 1'b0;
      if (abortReq) begin
        state <= IDLE;
      end else if (armNow) begin
        state     <= ARMED;
        wrPtr     <= '0;
        decCnt    <= '0;
        count     <= '0;
        modeLat   <= modeNxt;
        decimLat  <= decimNxt;
        lengthLat <= lengthNxt[DEPTH_LOG2-1:0];
      end else if (take) begin
        count  <= wrPtr;
        decCnt <= '0;
        if (lastWrite) begin
          state       <= DONE;
          captureDone <= 1'b1;
        end else begin
          wrPtr <= wrPtr + 1'b1;
          state <= CAPTURE;
        end
      end else if (vld_p0 && state == CAPTURE) begin
        decCnt <= decCnt + 1'b1;
      end
    end
  end

  // Stage p1: RAM write of the qualified sample, plus the synchronous
  // micro-side read port.
  always_ff @(posedge clk) begin
    if (take) mem[wrPtr] <= word;
    ramQ <= mem[addr[DEPTH_LOG2+1:2]];
  end

  // Registered register-space read and read-source select.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regQ   <= '0;
      bufSel <= 1'b0;
    end else begin
      regQ   <= regCs ? regMux : 32'd0;
      bufSel <= bufCs;
    end
  end

  assign dout = bufSel ? ramQ : regQ;

endmodule

// File: tb/tb_ddc_capture_buffer.sv
// Bench for ddc_capture_buffer. Stimulus tasks queue the expected read data.
// A monitor pops that data and compares it on the cycle the read returns.
// Expected records come from a sample-list model of trigger and decimation.
module tb_ddc_capture_buffer;
  logic               clk = 1'b0;
  logic               reset;
  logic               wr0, wr1, wr2, wr3;
  logic [12:0]        addr;
  logic [31:0]        din;
  logic               regCs, bufCs;
  logic [31:0]        dout;
  logic               syncIn;
  logic signed [17:0] iIn, qIn;
  logic               captureDone;

  ddc_capture_buffer #(.DEPTH_LOG2(10), .DATA_W(18)) dut (
    .clk(clk), .reset(reset), .wr0(wr0), .wr1(wr1), .wr2(wr2), .wr3(wr3),
    .addr(addr), .din(din), .regCs(regCs), .bufCs(bufCs), .dout(dout),
    .syncIn(syncIn), .iIn(iIn), .qIn(qIn), .captureDone(captureDone)
  );

  always #5 clk = ~clk;

  int          nCmp = 0;
  int          nBad = 0;
  int          doneCount = 0;
  int          doneBefore = 0;
  logic [31:0] expQ[$];
  string       nameQ[$];
  logic        rdIssue = 1'b0;
  logic        rdIssueD = 1'b0;
  logic        prevDone = 1'b0;
  logic [31:0] eV;
  string       eN;
  int          sI[$], sQ[$];
  int          mMode, mDecim, mLen, mThr;
  int          lastCnt;

  always @(posedge clk) rdIssueD <= rdIssue;

  // Monitor: read responses and captureDone pulses.
  always @(negedge clk) begin
    if (rdIssueD) begin
      nCmp++;
      if (expQ.size() == 0) begin
        nBad++;
        $display("FAIL rdQueue: read returned %h with nothing expected", dout);
      end else begin
        eV = expQ.pop_front();
        eN = nameQ.pop_front();
        if (dout !== eV) begin
          nBad++;
          $display("FAIL %s: got %h, expected %h", eN, dout, eV);
        end
      end
    end
    if (captureDone === 1'b1) begin
      nCmp++;
      doneCount++;
      if (prevDone === 1'b1) begin
        nBad++;
        $display("FAIL donePulseWidth: captureDone high for more than one clk");
      end
    end
    prevDone = captureDone;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nCmp++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  task automatic regWr(input logic [1:0] sel, input logic [31:0] d, input logic [3:0] lanes);
    regCs = 1'b1;
    addr  = {9'd0, sel, 2'b00};
    din   = d;
    {wr3, wr2, wr1, wr0} = lanes;
    tick();
    regCs = 1'b0;
    {wr3, wr2, wr1, wr0} = 4'b0000;
    din = '0;
  endtask

  task automatic rd(input logic isBuf, input int idx, input logic [31:0] exp, input string nm);
    addr = 13'(idx << 2);
    if (isBuf) bufCs = 1'b1;
    else       regCs = 1'b1;
    expQ.push_back(exp);
    nameQ.push_back(nm);
    rdIssue = 1'b1;
    tick();
    regCs = 1'b0;
    bufCs = 1'b0;
    rdIssue = 1'b0;
  endtask

  task automatic sample(input int i, input int q);
    syncIn = 1'b1;
    iIn = 18'(i);
    qIn = 18'(q);
    sI.push_back(i);
    sQ.push_back(q);
    tick();
    syncIn = 1'b0;
  endtask

  // Abort whatever is running, then arm a new record.
  task automatic armCap(input int mode, input int decim, input int len);
    logic [9:0] l;
    logic [3:0] d;
    l = 10'(len);
    d = 4'(decim);
    regWr(2'd0, 32'h2, 4'b0001);
    regWr(2'd0, {6'd0, l, 8'd0, d, 1'b0, 1'(mode), 2'b01}, 4'b1111);
    sI.delete();
    sQ.delete();
    mMode = mode;
    mDecim = decim;
    mLen = len;
    doneBefore = doneCount;
  endtask

  function automatic int mag(input int x);
    int m;
    m = (x < 0) ? -x : x;
    if (m > 131071) m = 131071;
    return m;
  endfunction

  // Model: the first qualifying sample after ARM is the trigger.
  // Then every (DECIM+1)th sample is kept, until LENGTH+1 have been stored.
  task automatic checkRecord(input string tag);
    int trig, idx, nst, st, cnt;
    logic [31:0] w;
    idle(3);
    trig = -1;
    for (int k = 0; k < sI.size(); k++) begin
      if (mMode == 0 || mag(sI[k]) >= mThr || mag(sQ[k]) >= mThr) begin
        trig = k;
        break;
      end
    end
    nst = 0;
    if (trig >= 0)
      for (int j = 0; j <= mLen; j++)
        if (trig + j * (mDecim + 1) < sI.size()) nst++;
    st  = (nst == mLen + 1) ? 3 : (nst > 0) ? 2 : 1;
    cnt = (nst > 0) ? nst - 1 : 0;
    lastCnt = cnt;
    rd(1'b0, 2, 32'((cnt << 16) | st), {tag, "_status"});
    for (int j = 0; j < nst; j++) begin
      idx = trig + j * (mDecim + 1);
      w = 32'((((sI[idx] >>> 2) & 'hFFFF) << 16) | ((sQ[idx] >>> 2) & 'hFFFF));
      rd(1'b1, j, w, $sformatf("%s_word%0d", tag, j));
    end
    idle(2);
    chk({tag, "_donePulses"}, 32'(doneCount - doneBefore), 32'(st == 3));
  endtask

  initial begin
    reset = 1'b0;
    {wr3, wr2, wr1, wr0} = 4'b0000;
    addr = '0; din = '0; regCs = 1'b0; bufCs = 1'b0;
    syncIn = 1'b0; iIn = '0; qIn = '0;
    mMode = 0; mDecim = 0; mLen = 0; mThr = 0; lastCnt = 0;

    // Reset state.
    repeat (2) @(posedge clk);
    #3;
    chk("rst_dout", dout, 32'd0);
    chk("rst_captureDone", {31'd0, captureDone}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
    rd(1'b0, 2, 32'd0, "rst_status");
    rd(1'b0, 0, 32'd0, "rst_control");
    rd(1'b0, 1, 32'd0, "rst_thresh");

    // Byte-lane writes to THRESH.
    regWr(2'd1, 32'hFFF2ABCD, 4'b0111);
    rd(1'b0, 1, 32'h0002ABCD, "thresh_lanes012");
    regWr(2'd1, 32'hFFFFFF11, 4'b0001);
    rd(1'b0, 1, 32'h0002AB11, "thresh_lane0");

    // Immediate capture, back-to-back samples.
    armCap(0, 0, 7);
    rd(1'b0, 0, 32'h00070000, "imm_control");
    for (int n = 0; n < 10; n++) sample(n * 4, -n * 4);
    checkRecord("imm");

    // Threshold trigger on positive and negative ramps and on the minimum code.
    regWr(2'd1, 32'd1000, 4'b1111);
    mThr = 1000;
    armCap(1, 0, 3);
    for (int v = 0; v <= 2000; v += 100) sample(v, 0);
    checkRecord("thrPos");
    armCap(1, 0, 3);
    for (int v = 0; v <= 2000; v += 100) sample(-v, 0);
    checkRecord("thrNeg");
    regWr(2'd1, 32'd131071, 4'b1111);
    mThr = 131071;
    armCap(1, 0, 1);
    sample(1000, 0); sample(-5000, 0); sample(131070, 0);
    sample(-131072, 0); sample(7, 0); sample(9, 0);
    checkRecord("thrMin");

    // Decimation with syncIn every 4 clk. An ARM during CAPTURE is ignored.
    armCap(0, 3, 3);
    for (int n = 0; n < 16; n++) begin
      sample(n * 16, -n * 16 - 2);
      if (n == 1) begin
        regWr(2'd0, 32'h000A0001, 4'b1111);
        idle(2);
      end else begin
        idle(3);
      end
    end
    checkRecord("dec");
    rd(1'b0, 0, 32'h000A0000, "dec_controlLatched");

    // Abort after three stored samples.
    armCap(0, 0, 7);
    for (int n = 0; n < 3; n++) sample(n * 8, n * 8 + 3);
    checkRecord("abtPre");
    regWr(2'd0, 32'h2, 4'b0001);
    rd(1'b0, 2, 32'h00020000, "abt_status");
    idle(4);
    chk("abt_noDone", 32'(doneCount - doneBefore), 32'd0);

    // ARM and ABORT in the same write, first from DONE and then from IDLE.
    armCap(0, 0, 1);
    sample(100, 200); sample(300, 400);
    checkRecord("armAbtPre");
    regWr(2'd0, 32'h00050003, 4'b1111);
    rd(1'b0, 2, 32'(lastCnt << 16), "armAbt_fromDone");
    regWr(2'd0, 32'h3, 4'b0001);
    rd(1'b0, 2, 32'(lastCnt << 16), "armAbt_fromIdle");
    rd(1'b0, 0, 32'h00050000, "armAbt_control");

    // Asynchronous reset during CAPTURE, then a clean re-arm.
    armCap(0, 0, 15);
    for (int n = 0; n < 4; n++) sample(n * 32, n * 32);
    idle(2);
    regCs = 1'b1;
    addr = 13'h8;
    tick();
    chk("rst_preStatus", dout, 32'h00030002);
    #2;
    reset = 1'b0;
    #1;
    chk("rstMid_dout", dout, 32'd0);
    chk("rstMid_captureDone", {31'd0, captureDone}, 32'd0);
    regCs = 1'b0;
    idle(2);
    reset = 1'b1;
    tick();
    rd(1'b0, 2, 32'd0, "rstMid_status");
    rd(1'b0, 0, 32'd0, "rstMid_control");
    rd(1'b0, 1, 32'd0, "rstMid_thresh");
    chk("rstMid_noDone", 32'(doneCount - doneBefore), 32'd0);
    mThr = 0;
    armCap(0, 0, 3);
    for (int n = 0; n < 6; n++) sample(1000 + n * 12, -2000 - n * 12);
    checkRecord("reArm");

    // Randomized records. The sample count is sometimes too small to finish.
    for (int it = 0; it < 8; it++) begin
      int mode, thr, decim, len, n, v, w;
      mode  = int'($urandom_range(0, 1));
      thr   = int'($urandom_range(0, 131071));
      decim = int'($urandom_range(0, 3));
      len   = int'($urandom_range(0, 12));
      regWr(2'd1, 32'(thr), 4'b1111);
      mThr = thr;
      armCap(mode, decim, len);
      n = (len + 1) * (decim + 1) + int'($urandom_range(0, 6)) - int'($urandom_range(0, 3));
      if (n < 1) n = 1;
      for (int k = 0; k < n; k++) begin
        v = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? -131072 : 131071)
                                        : int'($urandom_range(0, 262143)) - 131072;
        w = int'($urandom_range(0, 262143)) - 131072;
        sample(v, w);
        idle(int'($urandom_range(0, 2)));
      end
      checkRecord($sformatf("rnd%0d", it));
    end

    idle(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
